// File: rtl/gfp_pkg.sv
// Shared types and field constants for the limb-serial GF(p) adder/subtractor.
package gfp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      SEL   = 2'd3
   } state_t;

   // 2^255 - 19
   localparam logic [255:0] P25519   = {1'b0, {255{1'b1}}} - 256'd18;
   // 2^256 - 189, large enough that a+b overflows 256 bits
   localparam logic [255:0] P256M189 = {256{1'b1}} - 256'd188;

endpackage

// File: rtl/limb_addsub.sv
// One LIMB-wide carry/borrow stage: r = x+y+ci or r = x-y-ci, co is carry or borrow out.
module limb_addsub #(
   parameter int LIMB = 64
) (
   input  logic [LIMB-1:0] x,
   input  logic [LIMB-1:0] y,
   input  logic            ci,
   input  logic            sub,
   output logic [LIMB-1:0] r,
   output logic            co
);

   logic [LIMB:0] ext;

   // In subtract mode bit LIMB of the (LIMB+1)-bit difference is the borrow.
   always_comb begin
      ext = '0;
      if (sub) ext = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, ci};
      else     ext = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, ci};
   end

   assign r  = ext[LIMB-1:0];
   assign co = ext[LIMB];

endmodule

// File: rtl/gfp_addsub_serial.sv
// Limb-serial (a+b) mod p / (a-b) mod p: pass 1 forms s, pass 2 forms the corrected t,
// and SEL picks whichever of s/t is the reduced value.
module gfp_addsub_serial
   import gfp_pkg::*;
#(
   parameter int WIDTH = 256,
   parameter int LIMB  = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] p,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int NLIMB = WIDTH / LIMB;
   localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

   if (WIDTH % LIMB != 0) begin : g_bad_limb
      $error("WIDTH must be a multiple of LIMB");
   end

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ra, rb, rp, rs, rt;
   logic             op_sub, c, w1, w2;
   logic [LIMB-1:0]  lx, ly, lr;
   logic             lci, lsub, lco;
   logic             last;
   logic [WIDTH-1:0] sel_val;

   function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x);
      return (x >> LIMB) | (x << (WIDTH - LIMB));
   endfunction

   function automatic logic [WIDTH-1:0] shin(input logic [WIDTH-1:0] x, input logic [LIMB-1:0] l);
      return (x >> LIMB) | (WIDTH'(l) << (WIDTH - LIMB));
   endfunction

   assign last = (cnt == LAST);

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      case (state)
         IDLE:    if (start) state_nx = PASS1;
         PASS1:   if (last)  state_nx = PASS2;
         PASS2:   if (last)  state_nx = SEL;
         SEL:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // PASS2 reuses the same stage with the opposite operation, s against p.
   always_comb begin
      lx   = rs[LIMB-1:0];
      ly   = rp[LIMB-1:0];
      lci  = w2;
      lsub = ~op_sub;
      if (state == PASS1) begin
         lx   = ra[LIMB-1:0];
         ly   = rb[LIMB-1:0];
         lci  = op_sub ? w1 : c;
         lsub = op_sub;
      end
   end

   limb_addsub #(.LIMB(LIMB)) u_limb (
      .x   (lx),
      .y   (ly),
      .ci  (lci),
      .sub (lsub),
      .r   (lr),
      .co  (lco)
   );

   // Add: s >= p exactly when a+b overflowed or s-p did not borrow.
   always_comb begin
      sel_val = rs;
      if (op_sub) begin
         if (w1) sel_val = rt;
      end else begin
         if (c | ~w2) sel_val = rt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         ra     <= '0;
         rb     <= '0;
         rp     <= '0;
         rs     <= '0;
         rt     <= '0;
         op_sub <= 1'b0;
         c      <= 1'b0;
         w1     <= 1'b0;
         w2     <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ra     <= a;
                  rb     <= b;
                  rp     <= p;
                  op_sub <= mode;
                  c      <= 1'b0;
                  w1     <= 1'b0;
                  w2     <= 1'b0;
                  cnt    <= '0;
               end
            end
            PASS1: begin
               ra <= rot(ra);
               rb <= rot(rb);
               rs <= shin(rs, lr);
               if (op_sub) w1 <= lco;
               else        c  <= lco;
               cnt <= last ? '0 : cnt + 1'b1;
            end
            PASS2: begin
               rp  <= rot(rp);
               rs  <= rot(rs);
               rt  <= shin(rt, lr);
               w2  <= lco;
               cnt <= last ? '0 : cnt + 1'b1;
            end
            SEL: begin
               result <= sel_val;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gfp_addsub_serial.sv
// Self-checking bench for gfp_addsub_serial: directed field cases plus a randomized
// 64-bit/16-bit-limb instance checked against a plain modular-arithmetic model.
module tb_gfp_addsub_serial;
   import gfp_pkg::*;

   localparam int LAT = 9;
   localparam logic [63:0] P61 = 64'h1FFF_FFFF_FFFF_FFFF;

   logic         clk;
   logic         reset;
   logic         start;
   logic         mode;
   logic [255:0] a, b, p;
   logic         busy, done;
   logic [255:0] result;

   logic         start64, mode64;
   logic [63:0]  a64, b64, p64;
   logic         busy64, done64;
   logic [63:0]  result64;

   int errors = 0;
   int checks = 0;

   gfp_addsub_serial dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .p      (p),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   gfp_addsub_serial #(.WIDTH(64), .LIMB(16)) dut64 (
      .clk    (clk),
      .reset  (reset),
      .start  (start64),
      .mode   (mode64),
      .a      (a64),
      .b      (b64),
      .p      (p64),
      .busy   (busy64),
      .done   (done64),
      .result (result64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [255:0] model256(input logic m, input logic [255:0] x, input logic [255:0] y,
                                             input logic [255:0] q);
      logic [256:0] s;
      if (!m) begin
         s = {1'b0, x} + {1'b0, y};
         if (s >= {1'b0, q}) s = s - {1'b0, q};
         return s[255:0];
      end
      if (x >= y) return x - y;
      return q - (y - x);
   endfunction

   function automatic logic [63:0] model64(input logic m, input logic [63:0] x, input logic [63:0] y,
                                           input logic [63:0] q);
      logic [64:0] s;
      if (!m) begin
         s = {1'b0, x} + {1'b0, y};
         if (s >= {1'b0, q}) s = s - {1'b0, q};
         return s[63:0];
      end
      if (x >= y) return x - y;
      return q - (y - x);
   endfunction

   // Issues one 256-bit op, scrambles the inputs after accept, waits (bounded) for done.
   task automatic op256(input logic m, input logic [255:0] ia, input logic [255:0] ib, input logic [255:0] ip,
                        output logic [255:0] r, output int lat, output logic busy_acc, output logic busy_done);
      @(negedge clk);
      start = 1'b1; mode = m; a = ia; b = ib; p = ip;
      @(posedge clk); #1;
      start = 1'b0; busy_acc = busy;
      a = rand256(); b = rand256(); p = rand256(); mode = ~m;
      lat = -1; r = '0; busy_done = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i; r = result; busy_done = busy;
            break;
         end
      end
      if (lat < 0) begin
         errors++;
         $display("FAIL op256_timeout: no done within 40 cycles, required done after %0d", LAT);
      end
   endtask

   task automatic op64(input logic m, input logic [63:0] ia, input logic [63:0] ib, input logic [63:0] ip,
                       output logic [63:0] r, output int lat);
      @(negedge clk);
      start64 = 1'b1; mode64 = m; a64 = ia; b64 = ib; p64 = ip;
      @(posedge clk); #1;
      start64 = 1'b0;
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; p64 = {$urandom, $urandom}; mode64 = ~m;
      lat = -1; r = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done64) begin
            lat = i; r = result64;
            break;
         end
      end
      if (lat < 0) begin
         errors++;
         $display("FAIL op64_timeout: no done within 40 cycles, required done after %0d", LAT);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; p = '0;
      start64 = 1'b0; mode64 = 1'b0; a64 = '0; b64 = '0; p64 = '0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      checks++; if (result64 !== '0) begin errors++; $display("FAIL reset_result64: got %h want 0", result64); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_release: busy=%b done=%b want 0/0", busy, done);
      end
   endtask

   task automatic test_basic();
      logic [255:0] r;
      int lat;
      logic ba, bd;
      op256(1'b0, P25519 - 256'd1, 256'd1, P25519, r, lat, ba, bd);
      checks++; if (r !== '0) begin errors++; $display("FAIL add_wrap: got %h want 0", r); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL latency: got %0d want %0d", lat, LAT); end
      checks++; if (ba !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b want 1", ba); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b want 0", bd); end
      op256(1'b0, 256'd5, 256'd7, P25519, r, lat, ba, bd);
      checks++; if (r !== 256'd12) begin errors++; $display("FAIL add_small: got %h want 12", r); end
      op256(1'b1, 256'd3, 256'd5, P25519, r, lat, ba, bd);
      checks++; if (r !== P25519 - 256'd2) begin errors++; $display("FAIL sub_neg: got %h want %h", r, P25519 - 256'd2); end
      op256(1'b1, 256'h1234, 256'h1234, P25519, r, lat, ba, bd);
      checks++; if (r !== '0) begin errors++; $display("FAIL sub_equal: got %h want 0", r); end
      for (int i = 0; i < 6; i++) begin
         logic [255:0] x, y;
         logic m;
         x = rand256() % P25519; y = rand256() % P25519; m = 1'(i % 2);
         op256(m, x, y, P25519, r, lat, ba, bd);
         checks++; if (r !== model256(m, x, y, P25519)) begin
            errors++; $display("FAIL rand25519 m=%0d: got %h want %h", m, r, model256(m, x, y, P25519));
         end
      end
   endtask

   task automatic test_carry();
      logic [255:0] r;
      int lat;
      logic ba, bd;
      op256(1'b0, P256M189 - 256'd1, P256M189 - 256'd1, P256M189, r, lat, ba, bd);
      checks++; if (r !== P256M189 - 256'd2) begin
         errors++; $display("FAIL add_carry_out: got %h want %h", r, P256M189 - 256'd2);
      end
      op256(1'b1, 256'd0, P256M189 - 256'd1, P256M189, r, lat, ba, bd);
      checks++; if (r !== 256'd1) begin errors++; $display("FAIL sub_max: got %h want 1", r); end
   endtask

   task automatic test_reset_mid();
      logic [255:0] r;
      int lat, ndone;
      logic ba, bd;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; a = 256'd5; b = 256'd7; p = P25519;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b want 0", done); end
      checks++; if (result !== '0) begin errors++; $display("FAIL mid_reset_result: got %h want 0", result); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      checks++; if (ndone != 0) begin errors++; $display("FAIL aborted_done: got %0d pulses want 0", ndone); end
      op256(1'b0, 256'd1, 256'd1, P25519, r, lat, ba, bd);
      checks++; if (r !== 256'd2) begin errors++; $display("FAIL after_reset_add: got %h want 2", r); end
   endtask

   task automatic test_start_held();
      logic [255:0] x, y, r, exp_r;
      int ndone, lat;
      x = rand256() % P25519; y = rand256() % P25519;
      exp_r = model256(1'b0, x, y, P25519);
      ndone = 0; lat = -1; r = '0;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; a = x; b = y; p = P25519;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++; r = result; start = 1'b0;
            if (lat < 0) lat = i;
         end
         a = rand256(); b = rand256(); p = rand256(); mode = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      checks++; if (ndone != 1) begin errors++; $display("FAIL held_start_dones: got %0d want 1", ndone); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL held_start_latency: got %0d want %0d", lat, LAT); end
      checks++; if (r !== exp_r) begin errors++; $display("FAIL held_start_result: got %h want %h", r, exp_r); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_start_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_random64();
      logic [63:0] x, y, r, exp_r;
      logic m;
      int lat;
      for (int i = 0; i < 2000; i++) begin
         m = 1'($urandom_range(0, 1));
         x = {$urandom, $urandom} % P61;
         y = {$urandom, $urandom} % P61;
         if (i % 100 == 0) x = P61 - 64'd1;
         if (i % 100 == 1) y = P61 - 64'd1;
         if (i % 100 == 2) begin x = '0; y = P61 - 64'd1; end
         exp_r = model64(m, x, y, P61);
         op64(m, x, y, P61, r, lat);
         checks++; if (r !== exp_r) begin
            errors++; $display("FAIL rand64 m=%0d a=%h b=%h: got %h want %h", m, x, y, r, exp_r);
         end
         checks++; if (lat != LAT) begin errors++; $display("FAIL rand64_latency: got %0d want %0d", lat, LAT); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_reset_mid();
      test_start_held();
      test_random64();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
